// File: rtl/odesa_pkg.sv
// Shared types and constants for the ODESA training-sequence scheduler.
package odesa_pkg;

  localparam int NUM_EVT   = 8;
  localparam int NUM_LBL   = 4;
  localparam int EVT_IDX_W = $clog2(NUM_EVT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [EVT_IDX_W-1:0] onehot_to_idx(input logic [NUM_EVT-1:0] onehot);
    onehot_to_idx = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (onehot[i]) onehot_to_idx = EVT_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/odesa_rr_arbiter.sv
// 8-way round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module odesa_rr_arbiter
  import odesa_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [NUM_EVT-1:0] req,
  output logic [NUM_EVT-1:0] grant
);

  logic [EVT_IDX_W-1:0] last_idx;
  logic [EVT_IDX_W-1:0] idx;
  logic                 found;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path can leave a value held and infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Search starts one past the last grant; the index width makes it wrap 8 -> 1.
    for (int i = 1; i <= NUM_EVT; i++) begin
      idx = last_idx + EVT_IDX_W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      last_idx <= EVT_IDX_W'(NUM_EVT - 1);
    end else if (en && found) begin
      last_idx <= onehot_to_idx(grant);
    end
  end

endmodule

// File: rtl/odesa_event_scheduler.sv
// Latches event/label requests and issues them to the ODESA network as spaced
// one-hot pulses, counting labelled samples into epochs.
module odesa_event_scheduler
  import odesa_pkg::*;
#(
  parameter int p_gap   = 4,
  parameter int p_cnt_w = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [p_cnt_w-1:0] i_num_samples,
  input  logic [p_cnt_w-1:0] i_num_epochs,
  input  logic [NUM_EVT:1]   i_event_req,
  input  logic               i_label_req,
  input  logic [NUM_LBL:1]   i_label,
  output logic [NUM_EVT:1]   o_event,
  output logic [NUM_LBL:1]   o_label,
  output logic               o_endof_epochs,
  output logic [p_cnt_w-1:0] o_epoch,
  output logic               o_busy,
  output logic               o_drop
);

  localparam int GAP_W = (p_gap > 1) ? $clog2(p_gap) : 1;

  state_t               state;
  state_t               state_next;
  logic [NUM_EVT-1:0]   pending;
  logic [NUM_EVT-1:0]   grant;
  logic                 label_valid;
  logic [NUM_LBL-1:0]   label_val;
  logic [p_cnt_w-1:0]   sample_cnt;
  logic [p_cnt_w-1:0]   num_samples;
  logic [p_cnt_w-1:0]   num_epochs;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 start_ok;
  logic                 active;
  logic                 evt_fire;
  logic                 lbl_fire;
  logic                 gap_done;

  odesa_rr_arbiter u_arbiter (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (start_ok),
    .en    (evt_fire),
    .req   (pending),
    .grant (grant)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = RUN;
      RUN:        if (evt_fire || lbl_fire) state_next = GAP;
      GAP: begin
        if (gap_done) state_next = (o_epoch == num_epochs) ? DONE : RUN;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    start_ok = i_start && ((state == IDLE) || (state == DONE));
    active   = (state == RUN) || (state == GAP);
    o_busy   = active;
    // Events always win; a label only closes a sample once events have drained.
    evt_fire = (state == RUN) && (|pending);
    lbl_fire = (state == RUN) && !(|pending) && label_valid;
    gap_done = (gap_cnt == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_event        <= '0;
      o_label        <= '0;
      o_drop         <= 1'b0;
      o_endof_epochs <= 1'b0;
      o_epoch        <= '0;
      pending        <= '0;
      label_valid    <= 1'b0;
      label_val      <= '0;
      sample_cnt     <= '0;
      num_samples    <= p_cnt_w'(1);
      num_epochs     <= p_cnt_w'(1);
      gap_cnt        <= '0;
    end else begin
      o_event        <= evt_fire ? grant : '0;
      o_label        <= lbl_fire ? label_val : '0;
      o_drop         <= active && i_label_req && label_valid && !lbl_fire;
      o_endof_epochs <= (state == DONE) && !start_ok;

      if (evt_fire || lbl_fire)        gap_cnt <= GAP_W'(p_gap - 1);
      else if ((state == GAP) && !gap_done) gap_cnt <= gap_cnt - GAP_W'(1);

      if (start_ok) begin
        pending     <= '0;
        label_valid <= 1'b0;
        label_val   <= '0;
        sample_cnt  <= '0;
        o_epoch     <= '0;
        num_samples <= (i_num_samples == '0) ? p_cnt_w'(1) : i_num_samples;
        num_epochs  <= (i_num_epochs == '0) ? p_cnt_w'(1) : i_num_epochs;
      end else if (active) begin
        // A request on the bit granted this cycle re-arms it for a later issue.
        pending <= (pending & ~(evt_fire ? grant : '0)) | i_event_req;

        if (i_label_req) begin
          label_valid <= 1'b1;
          label_val   <= i_label;
        end else if (lbl_fire) begin
          label_valid <= 1'b0;
        end

        if (lbl_fire) begin
          if (sample_cnt == num_samples - p_cnt_w'(1)) begin
            sample_cnt <= '0;
            o_epoch    <= o_epoch + p_cnt_w'(1);
          end else begin
            sample_cnt <= sample_cnt + p_cnt_w'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_odesa_event_scheduler.sv
// Directed bench for odesa_event_scheduler: pulse logs with cycle stamps checked
// against hand-computed issue times.
module tb_odesa_event_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_num_samples = '0;
  logic [7:0] i_num_epochs = '0;
  logic [8:1] i_event_req = '0;
  logic       i_label_req = 1'b0;
  logic [4:1] i_label = '0;
  logic [8:1] o_event;
  logic [4:1] o_label;
  logic       o_endof_epochs;
  logic [7:0] o_epoch;
  logic       o_busy;
  logic       o_drop;

  odesa_event_scheduler #(.p_gap(4), .p_cnt_w(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_num_samples  (i_num_samples),
    .i_num_epochs   (i_num_epochs),
    .i_event_req    (i_event_req),
    .i_label_req    (i_label_req),
    .i_label        (i_label),
    .o_event        (o_event),
    .o_label        (o_label),
    .o_endof_epochs (o_endof_epochs),
    .o_epoch        (o_epoch),
    .o_busy         (o_busy),
    .o_drop         (o_drop)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic [7:0] ep;
  } rec_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   endof_cyc = -1;
  rec_t ev_q[$];
  rec_t lb_q[$];
  int   drop_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_event != '0) ev_q.push_back('{cyc, o_event, o_epoch});
    if (o_label != '0) lb_q.push_back('{cyc, {4'h0, o_label}, o_epoch});
    if (o_drop) drop_q.push_back(cyc);
    if (o_endof_epochs && endof_cyc < 0) endof_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    ev_q.delete();
    lb_q.delete();
    drop_q.delete();
    endof_cyc = -1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    clear_logs();
  endtask

  task automatic start(input logic [7:0] ns, input logic [7:0] ne);
    i_num_samples = ns;
    i_num_epochs  = ne;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pulse_evt(input logic [8:1] mask);
    i_event_req = mask;
    tick();
    i_event_req = '0;
  endtask

  task automatic pulse_lbl(input logic [4:1] l);
    i_label_req = 1'b1;
    i_label = l;
    tick();
    i_label_req = 1'b0;
    i_label = '0;
  endtask

  int base;

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_event", o_event, 0);
    check("rst_label", o_label, 0);
    check("rst_endof", o_endof_epochs, 0);
    check("rst_epoch", o_epoch, 0);
    check("rst_busy", o_busy, 0);
    check("rst_drop", o_drop, 0);

    // Single event then label, one sample, one epoch
    start(8'd1, 8'd1);
    check("t1_busy", o_busy, 1);
    base = cyc;
    pulse_evt(8'h01);
    pulse_lbl(4'h1);
    repeat (16) tick();
    check("t1_ev_n", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check("t1_ev_val", ev_q[0].val, 8'h01);
      check("t1_ev_cyc", ev_q[0].cyc, base + 2);
    end
    check("t1_lb_n", lb_q.size(), 1);
    if (lb_q.size() > 0) begin
      check("t1_lb_val", lb_q[0].val, 8'h01);
      check("t1_lb_cyc", lb_q[0].cyc, base + 7);
    end
    check("t1_endof_cyc", endof_cyc, base + 12);
    check("t1_epoch", o_epoch, 1);
    check("t1_busy_done", o_busy, 0);
    check("t1_endof", o_endof_epochs, 1);

    // All-channel burst drained 1..8, second burst merges before any grant
    do_reset();
    start(8'd10, 8'd10);
    base = cyc;
    pulse_lbl(4'h2);
    tick();
    pulse_evt(8'hFF);
    tick();
    pulse_evt(8'hFF);
    repeat (50) tick();
    check("t2_lb_cyc", (lb_q.size() > 0) ? lb_q[0].cyc : -1, base + 2);
    check("t2_ev_n", ev_q.size(), 8);
    if (ev_q.size() == 8) begin
      check("t2_first_cyc", ev_q[0].cyc, base + 7);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t2_grant%0d", i + 1), ev_q[i].val, 8'h01 << i);
        if (i > 0) check($sformatf("t2_space%0d", i), ev_q[i].cyc - ev_q[i-1].cyc, 5);
      end
    end

    // Fairness: bit 1 held, bit 5 pulsed once after the first grant
    do_reset();
    start(8'd10, 8'd10);
    base = cyc;
    i_event_req = 8'h01;
    tick();
    tick();
    i_event_req = 8'h11;
    tick();
    i_event_req = 8'h01;
    repeat (12) tick();
    i_event_req = '0;
    repeat (12) tick();
    check("t3_ev_n_ge3", ev_q.size() >= 3, 1);
    if (ev_q.size() >= 3) begin
      check("t3_g0", ev_q[0].val, 8'h01);
      check("t3_g0_cyc", ev_q[0].cyc, base + 2);
      check("t3_g1", ev_q[1].val, 8'h10);
      check("t3_g1_cyc", ev_q[1].cyc, base + 7);
      check("t3_g2", ev_q[2].val, 8'h01);
    end

    // Label overwrite while events pending
    do_reset();
    start(8'd10, 8'd10);
    base = cyc;
    pulse_evt(8'h03);
    pulse_lbl(4'h1);
    tick();
    pulse_lbl(4'h4);
    repeat (16) tick();
    check("t4_ev_n", ev_q.size(), 2);
    check("t4_drop_n", drop_q.size(), 1);
    if (drop_q.size() > 0) check("t4_drop_cyc", drop_q[0], base + 4);
    check("t4_lb_n", lb_q.size(), 1);
    if (lb_q.size() > 0) begin
      check("t4_lb_val", lb_q[0].val, 8'h04);
      check("t4_lb_cyc", lb_q[0].cyc, base + 12);
    end

    // Epoch counting: 3 samples x 2 epochs
    do_reset();
    start(8'd3, 8'd2);
    base = cyc;
    for (int k = 0; k < 6; k++) begin
      pulse_lbl(4'h2);
      repeat (5) tick();
    end
    repeat (4) tick();
    check("t5_lb_n", lb_q.size(), 6);
    if (lb_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("t5_lb%0d_cyc", k + 1), lb_q[k].cyc, base + 2 + 6 * k);
        check($sformatf("t5_lb%0d_epoch", k + 1), lb_q[k].ep, (k < 2) ? 0 : (k < 5) ? 1 : 2);
      end
      check("t5_endof_cyc", endof_cyc, lb_q[5].cyc + 5);
    end
    check("t5_epoch", o_epoch, 2);
    check("t5_endof", o_endof_epochs, 1);
    clear_logs();
    pulse_evt(8'hFF);
    pulse_lbl(4'h1);
    repeat (12) tick();
    check("t5_after_ev", ev_q.size(), 0);
    check("t5_after_lb", lb_q.size(), 0);
    check("t5_still_done", o_endof_epochs, 1);

    // Reset in GAP with events pending, concurrent start ignored
    do_reset();
    start(8'd10, 8'd10);
    pulse_evt(8'h07);
    tick();
    check("t6_pre_event", o_event, 8'h01);
    check("t6_pre_busy", o_busy, 1);
    i_rst = 1'b1;
    i_start = 1'b1;
    tick();
    i_rst = 1'b0;
    i_start = 1'b0;
    check("t6_event", o_event, 0);
    check("t6_busy", o_busy, 0);
    check("t6_endof", o_endof_epochs, 0);
    check("t6_epoch", o_epoch, 0);
    clear_logs();
    repeat (10) tick();
    check("t6_idle_ev", ev_q.size(), 0);
    check("t6_idle_busy", o_busy, 0);
    start(8'd10, 8'd10);
    repeat (20) tick();
    check("t6_restart_ev", ev_q.size(), 0);
    check("t6_restart_busy", o_busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
